// File: rtl/div_unit_pkg.sv
// Shared types and constants for the iterative divider.
// Imported by div_unit and div_step.
package div_unit_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift {rem, dividend} left,
// trial-subtract the divisor and shift the quotient bit in.
module div_step
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] dvd_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] dvd_o
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;
    logic             qbit;

    // rem_i[WIDTH] is always 0, so the extra top bit only carries the borrow
    assign shifted = {rem_i, dvd_i[WIDTH-1]};
    assign trial   = shifted - {2'b00, dvs_i};
    assign qbit    = ~trial[WIDTH+1];

    always_comb begin
        rem_o = shifted[WIDTH:0];
        if (qbit) begin
            rem_o = trial[WIDTH:0];
        end
    end

    assign dvd_o = {dvd_i[WIDTH-2:0], qbit};

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 DIV/DIVU unit for the EX stage.
// Quotient to LO, remainder to HI; stalls the pipe while busy.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             is_signed,
    input  logic             annul,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_stall
);

    localparam int CW = $clog2(WIDTH) + 1;

    div_state_e       state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic             qneg_q;
    logic             rneg_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rout_q;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_dvd;
    logic [WIDTH-1:0] quo_d;
    logic [WIDTH-1:0] rout_d;

    assign a_neg = is_signed & a[WIDTH-1];
    assign b_neg = is_signed & b[WIDTH-1];
    assign a_mag = a_neg ? ('0 - a) : a;
    assign b_mag = b_neg ? ('0 - b) : b;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i (rem_q),
        .dvd_i (dvd_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .dvd_o (step_dvd)
    );

    // Final step result, sign-corrected before being registered
    assign quo_d  = qneg_q ? ('0 - step_dvd) : step_dvd;
    assign rout_d = rneg_q ? ('0 - step_rem[WIDTH-1:0])
                           : step_rem[WIDTH-1:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            rout_q  <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                DIV_IDLE: begin
                    if (start && !annul) begin
                        if (b == '0) begin
                            quo_q   <= '1;
                            rout_q  <= a;
                            done_q  <= 1'b1;
                            state_q <= DIV_DONE;
                        end else begin
                            dvd_q   <= a_mag;
                            dvs_q   <= b_mag;
                            rem_q   <= '0;
                            cnt_q   <= '0;
                            qneg_q  <= a_neg ^ b_neg;
                            rneg_q  <= a_neg;
                            busy_q  <= 1'b1;
                            state_q <= DIV_BUSY;
                        end
                    end
                end
                DIV_BUSY: begin
                    if (annul || !start) begin
                        busy_q  <= 1'b0;
                        state_q <= DIV_IDLE;
                    end else begin
                        rem_q <= step_rem;
                        dvd_q <= step_dvd;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CW'(WIDTH - 1)) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            quo_q   <= quo_d;
                            rout_q  <= rout_d;
                            state_q <= DIV_DONE;
                        end
                    end
                end
                DIV_DONE: begin
                    state_q <= DIV_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= DIV_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rout_q;
    assign div_stall = start & ~done_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic         annul = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_stall;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        int           at;
        string        name;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] last_q = '0;
    logic [W-1:0] last_r = '0;

    div_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .is_signed (is_signed),
        .annul     (annul),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_stall (div_stall)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] got,
                         input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    exp_t e;
    always @(negedge clk) begin
        if (resetn === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done at cycle %0d, expected none",
                         cyc);
            end else begin
                e = sb.pop_front();
                check({e.name, "_q"}, quotient, e.q);
                check({e.name, "_r"}, remainder, e.r);
                check({e.name, "_cycle"}, W'(cyc), W'(e.at));
            end
        end
    end

    // Issue one divide and hold start until done; returns at the done negedge
    task automatic issue(input string name, input logic [W-1:0] ai,
                         input logic [W-1:0] bi, input logic s,
                         input logic [W-1:0] eq, input logic [W-1:0] er);
        int t0;
        int lat;
        int nbusy;
        bit prof_ok;
        bit got_done;
        @(negedge clk);
        start     = 1'b1;
        a         = ai;
        b         = bi;
        is_signed = s;
        t0        = cyc;
        lat       = (bi == '0) ? 1 : W + 1;
        sb.push_back(exp_t'{eq, er, t0 + lat, name});
        last_q    = eq;
        last_r    = er;
        #1;
        prof_ok  = (div_stall === 1'b1);
        nbusy    = 0;
        got_done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (done === 1'b1) begin
                got_done = 1'b1;
                if (div_stall !== 1'b0 || busy !== 1'b0) prof_ok = 1'b0;
                break;
            end
            if (div_stall !== 1'b1) prof_ok = 1'b0;
            if (busy === 1'b1) nbusy++;
        end
        check({name, "_done_seen"}, W'(got_done), W'(1));
        check({name, "_stall_profile"}, W'(prof_ok), W'(1));
        check({name, "_busy_cycles"}, W'(nbusy), W'(lat - 1));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("reset_busy", W'(busy), '0);
        check("reset_done", W'(done), '0);
        check("reset_q", quotient, '0);
        check("reset_r", remainder, '0);
        @(negedge clk);
        resetn = 1'b1;

        issue("u_100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
        @(negedge clk);
        start = 1'b0;
        #1;
        check("u_100_7_idle_busy", W'(busy), '0);
        check("u_100_7_idle_done", W'(done), '0);

        issue("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1,
              32'hFFFF_FFFD, 32'hFFFF_FFFF);
        issue("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1,
              32'hFFFF_FFFD, 32'd1);
        issue("u_big_2", 32'hFFFF_FFF9, 32'd2, 1'b0,
              32'h7FFF_FFFC, 32'd1);
        issue("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1,
              32'h8000_0000, 32'd0);
        issue("u_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0,
              32'hFFFF_FFFF, 32'd0);
        issue("s_div0", 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd5);
        issue("u_div0", 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5);
        @(negedge clk);
        start = 1'b0;

        // annul at cycle 10 of a divide
        @(negedge clk);
        start     = 1'b1;
        a         = 32'd1000;
        b         = 32'd7;
        is_signed = 1'b0;
        repeat (10) @(negedge clk);
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0;
        start = 1'b0;
        #1;
        check("annul_busy", W'(busy), '0);
        check("annul_done", W'(done), '0);
        check("annul_q_kept", quotient, last_q);
        check("annul_r_kept", remainder, last_r);
        issue("annul_9_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0);
        @(negedge clk);
        start = 1'b0;

        // asynchronous reset at cycle 15 of a divide
        @(negedge clk);
        start     = 1'b1;
        a         = 32'd1000;
        b         = 32'd3;
        is_signed = 1'b0;
        repeat (15) @(negedge clk);
        resetn = 1'b0;
        start  = 1'b0;
        #1;
        check("rst_busy", W'(busy), '0);
        check("rst_done", W'(done), '0);
        check("rst_q", quotient, '0);
        check("rst_r", remainder, '0);
        @(negedge clk);
        resetn = 1'b1;
        issue("rst_20_6", 32'd20, 32'd6, 1'b0, 32'd3, 32'd2);
        issue("rst_20_5", 32'd20, 32'd5, 1'b0, 32'd4, 32'd0);
        @(negedge clk);
        start = 1'b0;

        repeat (3) @(negedge clk);
        check("sb_drained", W'(sb.size()), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
